// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Purpose  : Shared constants and types for the 7-segment scan controller.
//            Holds the blank segment pattern, the hex-to-segment decode
//            table (active-low, bit order {g,f,e,d,c,b,a}) and the FSM
//            state type.
// Revision : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // All segments off (active-low drive).
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Index = hex nibble, value = active-low segments {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
        7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
        7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
        7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
    };

    // Per-slot phase: dark dead time, then the digit is shown.
    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_ctrl_if
// Purpose  : Bundles the producer-side data inputs and the display-side pin
//            outputs of the scan controller.
// Signals  : load       - one-cycle capture strobe for value/dp_in
//            value      - 4*N_DIGITS hex digits, digit 0 least significant
//            dp_in      - decimal point request per digit, active-high
//            en_mask    - per-digit enable, sampled live
//            lz_blank   - leading-zero suppression enable, sampled live
//            an         - anode drive, active-low
//            seg        - segments {g,f,e,d,c,b,a}, active-low
//            dp         - decimal point, active-low
//            frame_tick - one-cycle pulse at each frame start
// Modports : master - producer / board side, slave - scan controller
// Revision : 1.0 - initial release
// ============================================================================
interface seg7_scan_ctrl_if #(
    parameter int N_DIGITS = 4
);
    logic                    load;
    logic [4*N_DIGITS-1:0]   value;
    logic [N_DIGITS-1:0]     dp_in;
    logic [N_DIGITS-1:0]     en_mask;
    logic                    lz_blank;
    logic [N_DIGITS-1:0]     an;
    logic [6:0]              seg;
    logic                    dp;
    logic                    frame_tick;

    modport master (
        output load, value, dp_in, en_mask, lz_blank,
        input  an, seg, dp, frame_tick
    );

    modport slave (
        input  load, value, dp_in, en_mask, lz_blank,
        output an, seg, dp, frame_tick
    );
endinterface : seg7_scan_ctrl_if
`default_nettype wire

// File: rtl/seg7_hex_decode.sv
`default_nettype none
// ============================================================================
// Module   : seg7_hex_decode
// Purpose  : Combinational hex nibble to active-low 7-segment decoder.
// Ports    : i_nib - 4-bit hex digit
//            o_seg - segments {g,f,e,d,c,b,a}, active-low
// Revision : 1.0 - initial release
// ============================================================================
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_TABLE[i_nib];

endmodule : seg7_hex_decode
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_ctrl
// Purpose  : Time-multiplexed scan controller for an N-digit common-anode
//            7-segment display. Walks one digit slot every SLOT_CYCLES
//            clocks, keeps all anodes off for the first BLANK_CYCLES of each
//            slot, and shows a double-buffered hex value with per-digit
//            enable, leading-zero suppression and a frame-start tick.
// Ports    : clk   - system clock, rising edge
//            reset - asynchronous active-high reset
//            bus   - seg7_scan_ctrl_if.slave (data in, display pins out)
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int SLOT_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 8
) (
    input  logic              clk,
    input  logic              reset,
    seg7_scan_ctrl_if.slave   bus
);

    localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int IDX_W = (N_DIGITS > 1)    ? $clog2(N_DIGITS)    : 1;

    localparam logic [CNT_W-1:0] c_cnt_last   = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_blank_last = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] c_idx_last   = IDX_W'(N_DIGITS - 1);

    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    state_t                  r_state;
    logic [4*N_DIGITS-1:0]   r_pend_val;
    logic [N_DIGITS-1:0]     r_pend_dp;
    logic [4*N_DIGITS-1:0]   r_act_val;
    logic [N_DIGITS-1:0]     r_act_dp;
    logic [N_DIGITS-1:0]     r_an;
    logic [6:0]              r_seg;
    logic                    r_dp;
    logic                    r_frame_tick;

    logic                    w_slot_end;
    logic                    w_frame_end;
    logic [N_DIGITS-1:0]     w_zero_from;   // [k]: active nibbles k..N-1 all zero
    logic [N_DIGITS-1:0]     w_an_sel;
    logic [3:0]              w_nib;
    logic                    w_en;
    logic                    w_dp_act;
    logic                    w_supp;
    logic                    w_visible;
    logic [6:0]              w_seg;

    assign w_slot_end  = (r_cnt == c_cnt_last);
    assign w_frame_end = w_slot_end && (r_idx == c_idx_last);

    for (genvar k = 0; k < N_DIGITS; k++) begin : g_zero
        assign w_zero_from[k] = ~|r_act_val[4*N_DIGITS-1 : 4*k];
    end

    // Select everything belonging to the current digit slot.
    always_comb begin
        w_nib    = 4'h0;
        w_en     = 1'b0;
        w_dp_act = 1'b0;
        w_supp   = 1'b0;
        w_an_sel = '1;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_nib       = r_act_val[4*k +: 4];
                w_en        = bus.en_mask[k];
                w_dp_act    = r_act_dp[k];
                // Digit 0 always shows so an all-zero value still reads "0".
                w_supp      = bus.lz_blank && (k != 0) && w_zero_from[k];
                w_an_sel[k] = 1'b0;
            end
        end
    end

    assign w_visible = w_en && !w_supp;

    seg7_hex_decode u_dec (
        .i_nib (w_nib),
        .o_seg (w_seg)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_state      <= ST_BLANK;
            r_pend_val   <= '0;
            r_pend_dp    <= '0;
            r_act_val    <= '0;
            r_act_dp     <= '0;
            r_an         <= '1;
            r_seg        <= SEG_BLANK;
            r_dp         <= 1'b1;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_frame_end;

            if (w_slot_end) begin
                r_cnt <= '0;
                r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            // State tracks the counter so it changes together with it.
            case (r_state)
                ST_BLANK: if (r_cnt == c_blank_last) r_state <= ST_SHOW;
                ST_SHOW:  if (w_slot_end)            r_state <= ST_BLANK;
                default:                             r_state <= ST_BLANK;
            endcase

            // Pin drive reflects the state one cycle earlier.
            if (r_state == ST_SHOW && w_visible) begin
                r_an  <= w_an_sel;
                r_seg <= w_seg;
                r_dp  <= ~w_dp_act;
            end else begin
                r_an  <= '1;
                r_seg <= SEG_BLANK;
                r_dp  <= 1'b1;
            end

            if (bus.load) begin
                r_pend_val <= bus.value;
                r_pend_dp  <= bus.dp_in;
            end

            // Active only changes between frames; a load on the boundary
            // edge bypasses pending so it is not delayed a whole frame.
            if (w_frame_end) begin
                r_act_val <= bus.load ? bus.value : r_pend_val;
                r_act_dp  <= bus.load ? bus.dp_in : r_pend_dp;
            end
        end
    end

    assign bus.an         = r_an;
    assign bus.seg        = r_seg;
    assign bus.dp         = r_dp;
    assign bus.frame_tick = r_frame_tick;

endmodule : seg7_scan_ctrl
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_ctrl
// Purpose  : Directed self-checking bench for seg7_scan_ctrl with
//            N_DIGITS=4, SLOT_CYCLES=10, BLANK_CYCLES=2 (frame = 40 cycles).
//            Frame cycle f=0 is the cycle in which frame_tick is high; digit
//            i is lit for f = 10*i+3 .. 10*i+10.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_ctrl;

    localparam int N  = 4;
    localparam int SC = 10;
    localparam int BC = 2;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    logic [3:0] cap_an   [0:99];
    logic [6:0] cap_seg  [0:99];
    logic       cap_dp   [0:99];
    logic       cap_tick [0:99];

    seg7_scan_ctrl_if #(.N_DIGITS(N)) bus ();

    seg7_scan_ctrl #(
        .N_DIGITS     (N),
        .SLOT_CYCLES  (SC),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Load strobe for one cycle, driven between edges.
    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        @(negedge clk);
        bus.value = v;
        bus.dp_in = d;
        bus.load  = 1'b1;
        @(negedge clk);
        bus.load  = 1'b0;
    endtask

    // Advance to the next cycle with frame_tick high (bounded).
    task automatic wait_tick();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (bus.frame_tick === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL wait_tick: frame_tick not seen within 200 cycles");
        end
    endtask

    // Record n samples starting at the current negedge; optional load at j.
    task automatic capture(input int n, input int load_at, input logic [15:0] lv);
        for (int j = 0; j < n; j++) begin
            if (j > 0) @(negedge clk);
            cap_an[j]   = bus.an;
            cap_seg[j]  = bus.seg;
            cap_dp[j]   = bus.dp;
            cap_tick[j] = bus.frame_tick;
            if (j == load_at) begin
                bus.value = lv;
                bus.load  = 1'b1;
            end else begin
                bus.load  = 1'b0;
            end
        end
        bus.load = 1'b0;
    endtask

    function automatic int lit_count(input logic [3:0] pat, input int lo, input int hi);
        int c;
        c = 0;
        for (int f = lo; f <= hi; f++) if (cap_an[f] === pat) c++;
        return c;
    endfunction

    function automatic int tick_count(input int lo, input int hi);
        int c;
        c = 0;
        for (int f = lo; f <= hi; f++) if (cap_tick[f] === 1'b1) c++;
        return c;
    endfunction

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.an !== 4'hF) $display("FAIL reset_hold_an: got %h want f", bus.an);
        else n_pass++;
        reset = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++;
        if (bus.an !== 4'b1110) $display("FAIL pre_reset_lit: got %b want 1110", bus.an);
        else n_pass++;
        // Asynchronous assertion mid-slot, away from any edge.
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (bus.an !== 4'hF) $display("FAIL async_reset_an: got %h want f", bus.an);
        else n_pass++;
        n_checks++;
        if (bus.seg !== 7'h7F) $display("FAIL async_reset_seg: got %h want 7f", bus.seg);
        else n_pass++;
        n_checks++;
        if (bus.dp !== 1'b1) $display("FAIL async_reset_dp: got %b want 1", bus.dp);
        else n_pass++;
        n_checks++;
        if (bus.frame_tick !== 1'b0) $display("FAIL async_reset_tick: got %b want 0", bus.frame_tick);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.an !== 4'hF) $display("FAIL release_dark: got %b want 1111", bus.an);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus.an !== 4'b1110 || bus.seg !== 7'h40)
            $display("FAIL release_first_lit: got an=%b seg=%h want an=1110 seg=40", bus.an, bus.seg);
        else n_pass++;
    endtask

    task automatic test_scan_order();
        logic [3:0] exp_an  [4];
        logic [6:0] exp_seg [4];
        exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        exp_seg = '{7'h0E, 7'h08, 7'h24, 7'h79};
        bus.en_mask  = 4'hF;
        bus.lz_blank = 1'b0;
        do_load(16'h12AF, 4'h0);
        wait_tick();
        capture(41, -1, 16'h0);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (cap_an[10*i+5] !== exp_an[i] || cap_seg[10*i+5] !== exp_seg[i])
                $display("FAIL scan_digit%0d: got an=%b seg=%h want an=%b seg=%h",
                         i, cap_an[10*i+5], cap_seg[10*i+5], exp_an[i], exp_seg[i]);
            else n_pass++;
            n_checks++;
            if (lit_count(exp_an[i], 1, 40) != 8)
                $display("FAIL scan_lit_len%0d: got %0d want 8", i, lit_count(exp_an[i], 1, 40));
            else n_pass++;
            n_checks++;
            if (cap_an[10*i+1] !== 4'hF || cap_an[10*i+2] !== 4'hF)
                $display("FAIL scan_dead%0d: got %b %b want 1111 1111", i, cap_an[10*i+1], cap_an[10*i+2]);
            else n_pass++;
        end
        n_checks++;
        if (tick_count(1, 39) != 0 || cap_tick[40] !== 1'b1)
            $display("FAIL scan_tick_period: got mid=%0d end=%b want mid=0 end=1", tick_count(1, 39), cap_tick[40]);
        else n_pass++;
    endtask

    task automatic test_tearing();
        do_load(16'h1111, 4'h0);
        wait_tick();
        capture(81, 12, 16'h2222);
        for (int i = 1; i < 4; i++) begin
            n_checks++;
            if (cap_seg[10*i+5] !== 7'h79)
                $display("FAIL tear_old_digit%0d: got %h want 79", i, cap_seg[10*i+5]);
            else n_pass++;
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (cap_seg[40+10*i+5] !== 7'h24)
                $display("FAIL tear_new_digit%0d: got %h want 24", i, cap_seg[40+10*i+5]);
            else n_pass++;
        end
    endtask

    task automatic test_leading_zero();
        bus.lz_blank = 1'b1;
        do_load(16'h0050, 4'h0);
        wait_tick();
        capture(41, -1, 16'h0);
        n_checks++;
        if (cap_an[35] !== 4'hF || cap_an[25] !== 4'hF)
            $display("FAIL lz_suppressed: got d3=%b d2=%b want 1111 1111", cap_an[35], cap_an[25]);
        else n_pass++;
        n_checks++;
        if (cap_an[15] !== 4'b1101 || cap_seg[15] !== 7'h12)
            $display("FAIL lz_digit1: got an=%b seg=%h want an=1101 seg=12", cap_an[15], cap_seg[15]);
        else n_pass++;
        n_checks++;
        if (cap_an[5] !== 4'b1110 || cap_seg[5] !== 7'h40)
            $display("FAIL lz_digit0: got an=%b seg=%h want an=1110 seg=40", cap_an[5], cap_seg[5]);
        else n_pass++;
        bus.lz_blank = 1'b0;
        wait_tick();
        capture(41, -1, 16'h0);
        n_checks++;
        if (cap_an[35] !== 4'b0111 || cap_seg[35] !== 7'h40)
            $display("FAIL nolz_digit3: got an=%b seg=%h want an=0111 seg=40", cap_an[35], cap_seg[35]);
        else n_pass++;
        n_checks++;
        if (cap_an[25] !== 4'b1011 || cap_seg[25] !== 7'h40)
            $display("FAIL nolz_digit2: got an=%b seg=%h want an=1011 seg=40", cap_an[25], cap_seg[25]);
        else n_pass++;
    endtask

    task automatic test_enable_dp();
        bus.en_mask = 4'b0101;
        do_load(16'h4321, 4'b0001);
        wait_tick();
        capture(41, -1, 16'h0);
        n_checks++;
        if (cap_an[5] !== 4'b1110 || cap_seg[5] !== 7'h79 || cap_dp[5] !== 1'b0)
            $display("FAIL en_digit0: got an=%b seg=%h dp=%b want an=1110 seg=79 dp=0", cap_an[5], cap_seg[5], cap_dp[5]);
        else n_pass++;
        n_checks++;
        if (cap_an[25] !== 4'b1011 || cap_seg[25] !== 7'h30 || cap_dp[25] !== 1'b1)
            $display("FAIL en_digit2: got an=%b seg=%h dp=%b want an=1011 seg=30 dp=1", cap_an[25], cap_seg[25], cap_dp[25]);
        else n_pass++;
        n_checks++;
        if (lit_count(4'b1101, 0, 40) != 0 || lit_count(4'b0111, 0, 40) != 0 || cap_seg[15] !== 7'h7F)
            $display("FAIL en_disabled_dark: got d1=%0d d3=%0d lit cycles want 0 0",
                     lit_count(4'b1101, 0, 40), lit_count(4'b0111, 0, 40));
        else n_pass++;
        n_checks++;
        if (tick_count(1, 39) != 0 || cap_tick[40] !== 1'b1)
            $display("FAIL en_frame_len: got mid=%0d end=%b want mid=0 end=1", tick_count(1, 39), cap_tick[40]);
        else n_pass++;
    endtask

    task automatic test_boundary_load();
        bus.en_mask = 4'hF;
        bus.dp_in   = 4'h0;
        wait_tick();
        repeat (39) @(negedge clk);
        // f=39: the next rising edge is the frame boundary.
        bus.value = 16'hFFFF;
        bus.load  = 1'b1;
        @(negedge clk);
        bus.load  = 1'b0;
        n_checks++;
        if (bus.frame_tick !== 1'b1) $display("FAIL bnd_tick: got %b want 1", bus.frame_tick);
        else n_pass++;
        capture(41, -1, 16'h0);
        n_checks++;
        if (cap_seg[0] !== 7'h19)
            $display("FAIL bnd_old_tail: got %h want 19", cap_seg[0]);
        else n_pass++;
        n_checks++;
        if (cap_an[5] !== 4'b1110 || cap_seg[5] !== 7'h0E)
            $display("FAIL bnd_new_digit0: got an=%b seg=%h want an=1110 seg=0e", cap_an[5], cap_seg[5]);
        else n_pass++;
        n_checks++;
        if (cap_seg[35] !== 7'h0E)
            $display("FAIL bnd_new_digit3: got %h want 0e", cap_seg[35]);
        else n_pass++;
    endtask

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        reset        = 1'b1;
        bus.load     = 1'b0;
        bus.value    = 16'h0;
        bus.dp_in    = 4'h0;
        bus.en_mask  = 4'hF;
        bus.lz_blank = 1'b0;
        test_reset();
        test_scan_order();
        test_tearing();
        test_leading_zero();
        test_enable_dp();
        test_boundary_load();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_seg7_scan_ctrl
`default_nettype wire

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Time-multiplexed scan controller for an N-digit common-anode 7-segment display sharing one segment bus. Holds a double-buffered hex value and walks digit slots at a programmable refresh rate. Per slot, it drives one active-low anode and decodes that digit's nibble to active-low segments. Includes an anti-ghosting dead time per slot, per-digit enable, leading-zero suppression and a frame-boundary tick. Sits between the system-side data producer and the board's anode/segment pins.

Parameters:
N_DIGITS, 4, number of digits scanned (>=1)
SLOT_CYCLES, 50000, clock cycles per digit slot (> BLANK_CYCLES)
BLANK_CYCLES, 8, dead-time cycles at the start of each slot, all anodes off (>=1)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
load  in  1  capture strobe for value/dp_in, one cycle
value  in  4*N_DIGITS  hex digits; nibble k = digit k, digit 0 = least significant
dp_in  in  N_DIGITS  decimal point request per digit, active-high
en_mask  in  N_DIGITS  per-digit enable, sampled live each cycle
lz_blank  in  1  leading-zero suppression enable, sampled live
an  out  N_DIGITS  anode drive, active-low, at most one bit low
seg  out  7  segments {g,f,e,d,c,b,a}, active-low
dp  out  1  decimal point, active-low
frame_tick  out  1  one-cycle pulse at each frame start

Behaviour:
- Reset (async, while reset=1): an = all 1, seg = 7'h7F, dp = 1, frame_tick = 0, slot counter = 0, digit index = 0, pending and active buffers = 0, state = BLANK.
- Slot counter cnt runs 0..SLOT_CYCLES-1. At cnt = SLOT_CYCLES-1: cnt -> 0; idx -> idx+1, wrapping N_DIGITS-1 -> 0.
- FSM, two states:
  - BLANK while cnt < BLANK_CYCLES.
  - SHOW while cnt >= BLANK_CYCLES.
  - BLANK -> SHOW at cnt = BLANK_CYCLES-1.
  - SHOW -> BLANK at cnt = SLOT_CYCLES-1.
- Outputs are registered, with 1 cycle latency from cnt/idx/state.
  - In BLANK: an = all 1, seg = 7'h7F, dp = 1.
  - In SHOW for digit idx with the digit visible: an[idx] = 0, others 1; seg = decode(active nibble idx); dp = ~active_dp[idx].
  - In SHOW with the digit not visible: same as BLANK.
  - Each visible digit is lit for exactly SLOT_CYCLES-BLANK_CYCLES consecutive cycles per frame.
- Visible = en_mask[idx] AND NOT suppressed. A disabled slot still consumes its full time, so the refresh rate is constant.
- Leading-zero suppression: when lz_blank = 1, digit k > 0 is suppressed if it and all higher active nibbles are 0. Digit 0 is never suppressed. Decimal points are not suppressed; dp follows visibility.
- Double buffering:
  - load = 1 copies value/dp_in into pending.
  - At the frame boundary (idx wraps to 0 together with cnt -> 0), pending is copied into active.
  - If load coincides with the boundary edge, the new value/dp_in goes directly to active (bypass) and also to pending.
  - A mid-frame load never alters the frame in progress (no tearing).
- frame_tick = 1 for exactly one cycle, registered, in the cycle after the boundary edge.
- Decode table (active-low, {g..a}):
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
- Reset mid-slot returns immediately to the reset state; scanning restarts at digit 0, cnt 0, with buffers cleared.

Decomposition:
- Shared package seg7_pkg holds:
  - SEG_BLANK = 7'h7F
  - the 16-entry decode constant array (above)
  - the FSM state enum {ST_BLANK, ST_SHOW}
- One sub-module, seg7_hex_decode: purely combinational, 4-bit nibble in, 7-bit active-low segments out, built from the package table. Instantiated once on the muxed active nibble.
- All other logic (counter, FSM, buffers, LZ logic) stays in seg7_scan_ctrl.

Test Plan:
- Bench parameters: N_DIGITS=4, SLOT_CYCLES=10, BLANK_CYCLES=2.
- Reset: assert reset mid-slot -> same cycle an=4'hF, seg=7'h7F, dp=1, frame_tick=0. Release -> first lit digit is an=4'b1110 after 3 cycles.
- Scan order: load value=16'h12AF, en_mask=4'hF, lz_blank=0, then wait one frame -> per frame, an = 1110, 1101, 1011, 0111 with seg = 0E, 08, 24, 79. Each digit is lit 8 cycles after 2 dark cycles; frame_tick pulses once every 40 cycles.
- Tearing: value 16'h1111 active; load 16'h2222 at slot 1 of the frame -> the remaining slots of that frame still show 1 (seg=79); the next frame shows 2 (seg=24) on all digits.
- Leading zeros: value=16'h0050, lz_blank=1 -> digits 3 and 2 dark for their slots; digit1 seg=12; digit0 seg=40. With lz_blank=0 -> digits 3 and 2 show seg=40.
- Enable and dp: en_mask=4'b0101, dp_in=4'b0001 -> slots 1 and 3 fully dark while frame length stays 40 cycles. During digit 0, dp=0.
- Boundary load: pulse load exactly on the boundary edge with value=16'hFFFF -> the new frame shows F (seg=0E) starting from digit 0.
